// File: rtl/funnel_unshift_if.sv
// funnel_unshift_if: request/response bundle for funnel_unshift.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The side that raised valid
// holds valid and its payload stable until that edge. Valid never waits
// on ready. Ready may depend on internal state only.
//
// Signals:
//   in_valid/in_ready    request handshake (producer -> block)
//   data[63:0]           packed funnel word {hi, lo}
//   dir                  1 = original shift was left (undo shifts right)
//   shamt[5:0]           shift amount 0..63
//   out_valid/out_ready  result handshake (block -> consumer)
//   hi[31:0], lo[31:0]   result halves, meaningful only with out_valid
//   busy                 block is working or holding a result
//   dbg_state[1:0]       raw FSM state, for observation only
//
// Modports:
//   slave   the funnel_unshift block
//   master  the producer and consumer around it
interface funnel_unshift_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data;
    logic        dir;
    logic [5:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic [1:0]  dbg_state;

    modport slave (
        input  in_valid, data, dir, shamt, out_ready,
        output in_ready, out_valid, hi, lo, busy, dbg_state
    );

    modport master (
        output in_valid, data, dir, shamt, out_ready,
        input  in_ready, out_valid, hi, lo, busy, dbg_state
    );
endinterface

// File: rtl/funnel_unshift.sv
// funnel_unshift: multi-cycle inverse of the 64-bit funnel shifter.
//
// The block accepts a packed funnel word, a shift amount and the direction
// of the original shift. It applies the opposite logical shift STEP bits
// per cycle with zero fill. It then presents the 64-bit result as hi/lo
// and holds it until the consumer takes it.
//
// Parameters:
//   STEP   bits shifted per cycle, legal values 1, 2, 4, 8
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset. Its release must already be
//          synchronised to clk by the top level.
//   bus    funnel_unshift_if.slave (request, result, busy, dbg_state)
//
// Timing: a request accepted at edge E0 needs N = ceil(shamt/STEP) SHIFT
// cycles. out_valid is seen 1 + N cycles after acceptance. in_ready returns
// the cycle after the result is taken, with no same-cycle turnaround.
module funnel_unshift #(
    parameter int STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    funnel_unshift_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state;
    logic [63:0] acc;
    logic [5:0]  rem;
    logic        dir_q;

    logic [5:0]  k;
    logic [5:0]  rem_next;

    // The last step shifts only what is left, so rem lands exactly on zero
    // and never wraps.
    always_comb begin
        k        = (rem < STEP_W) ? rem : STEP_W;
        rem_next = rem - k;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            dir_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake.
                    if (bus.in_valid) begin
                        acc   <= bus.data;
                        rem   <= bus.shamt;
                        dir_q <= bus.dir;
                        state <= (bus.shamt == 6'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    // dir_q records the direction of the original shift.
                    // The undo shift goes the other way.
                    acc <= dir_q ? (acc >> k) : (acc << k);
                    rem <= rem_next;
                    if (rem_next == 6'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every output comes from state or acc, so no input reaches an output
    // in the same cycle.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.hi        = acc[63:32];
    assign bus.lo        = acc[31:0];
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_funnel_unshift.sv
// tb_funnel_unshift: self-checking bench for funnel_unshift.
//
// A driver task issues requests and pushes the reference result and the
// expected latency to queues. A collector task pops those queues when
// out_valid appears and compares result, latency and hold behaviour.
// Each scenario is a separate task, called in sequence from one initial
// block.
module tb_funnel_unshift;

    parameter int STEP = 4;

    localparam time HALF   = 5;
    localparam time PERIOD = 10;
    localparam int  BUDGET = 200;

    logic clk = 1'b0;
    logic rst;

    always #HALF clk = ~clk;

    funnel_unshift_if bus ();

    funnel_unshift #(.STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard state
    logic [63:0] exp_q[$];
    int          lat_q[$];
    time         acc_t_q[$];
    time         done_t;
    time         last_acc_t;

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic dr,
                                              input logic [5:0] s);
        return dr ? (d >> s) : (d << s);
    endfunction

    function automatic int ref_lat(input int s);
        return 1 + (s + STEP - 1) / STEP;
    endfunction

    // in_ready and out_valid are mutually exclusive in every cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.in_ready === 1'b1 && bus.out_valid === 1'b1) begin
            errors++;
            $display("FAIL ready_valid_exclusive: in_ready=1 out_valid=1 at %0t, required not both", $time);
        end
    end

    // Watchdog
    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- driver
    task automatic send_req(input logic [63:0] d, input logic dr, input logic [5:0] s);
        int n;
        n = 0;
        exp_q.push_back(ref_shift(d, dr, s));
        lat_q.push_back(ref_lat(int'(s)));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data     = d;
        bus.dir      = dr;
        bus.shamt    = s;
        while (bus.in_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
            bus.in_valid = 1'b0;
            void'(exp_q.pop_back());
            void'(lat_q.pop_back());
            return;
        end
        @(posedge clk);
        acc_t_q.push_back($time);
        last_acc_t = $time;
        #1;
        // Scramble inputs after acceptance; the block must ignore them.
        bus.in_valid = 1'b0;
        bus.data     = {$urandom(), $urandom()};
        bus.dir      = ~dr;
        bus.shamt    = 6'($urandom_range(0, 63));
    endtask

    // ------------------------------------------------------------- collector
    task automatic collect_resp(input int hold);
        int          n;
        int          lat;
        int          lat_exp;
        time         t_acc;
        logic [63:0] exp_v;
        n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (lat_q.size() > 0) void'(lat_q.pop_front());
            if (acc_t_q.size() > 0) void'(acc_t_q.pop_front());
            return;
        end
        if (exp_q.size() == 0 || acc_t_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: hi=%h lo=%h with no request outstanding, required none",
                     bus.hi, bus.lo);
            return;
        end
        exp_v   = exp_q.pop_front();
        lat_exp = lat_q.pop_front();
        t_acc   = acc_t_q.pop_front();
        lat     = int'((($time - HALF) - t_acc) / PERIOD) + 1;

        checks++;
        if (lat !== lat_exp) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, lat_exp);
        end
        checks++;
        if ({bus.hi, bus.lo} !== exp_v) begin
            errors++;
            $display("FAIL result: got %h_%h, required %h_%h", bus.hi, bus.lo, exp_v[63:32], exp_v[31:0]);
        end

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({bus.hi, bus.lo} !== exp_v || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold: cycle %0d got %h_%h ov=%b ir=%b, required %h_%h ov=1 ir=0",
                         h, bus.hi, bus.lo, bus.out_valid, bus.in_ready, exp_v[63:32], exp_v[31:0]);
            end
        end

        bus.out_ready = 1'b1;
        @(posedge clk);
        done_t = $time;
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic run_one(input logic [63:0] d, input logic dr, input logic [5:0] s, input int hold);
        fork
            send_req(d, dr, s);
            collect_resp(hold);
        join
    endtask

    // ------------------------------------------------------------- scenarios
    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.busy, bus.hi, bus.lo, bus.dbg_state} !==
                {1'b1, 1'b0, 1'b0, 64'd0, 2'd0}) begin
                errors++;
                $display("FAIL reset_state: ir=%b ov=%b busy=%b hi=%h lo=%h st=%0d, required 1 0 0 0 0 0",
                         bus.in_ready, bus.out_valid, bus.busy, bus.hi, bus.lo, bus.dbg_state);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_right_undo;
        run_one(64'h00000001_80000000, 1'b1, 6'd31, 0);
    endtask

    task automatic test_left_undo;
        run_one(64'h00000000_FFFFFFFF, 1'b0, 6'd32, 0);
    endtask

    task automatic test_boundaries;
        run_one(64'h12345678_9ABCDEF0, 1'b0, 6'd0, 0);
        run_one(64'h80000000_00000000, 1'b1, 6'd63, 0);
        run_one(64'hFFFFFFFF_FFFFFFFF, 1'b0, 6'd63, 0);
    endtask

    task automatic test_backpressure;
        run_one(64'hDEADBEEF_CAFEF00D, 1'b1, 6'd13, 5);
    endtask

    task automatic test_back_to_back;
        time t_done_a;
        fork
            begin
                send_req(64'hA5A5A5A5_5A5A5A5A, 1'b0, 6'd9);
                send_req(64'h0000FFFF_0000FFFF, 1'b1, 6'd17);
            end
            begin
                collect_resp(2);
                t_done_a = done_t;
                collect_resp(0);
            end
        join
        checks++;
        if (last_acc_t !== t_done_a + PERIOD) begin
            errors++;
            $display("FAIL b2b_accept: second accepted at %0t, required %0t", last_acc_t, t_done_a + PERIOD);
        end
    endtask

    task automatic test_reset_mid_shift;
        send_req(64'h0123456789ABCDEF, 1'b0, 6'd40);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift: busy=%b out_valid=%b, required 1/0", bus.busy, bus.out_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.hi, bus.lo} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL async_reset: ir=%b ov=%b busy=%b hi=%h lo=%h, required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.hi, bus.lo);
        end
        // The in-flight request is dropped.
        exp_q.delete();
        lat_q.delete();
        acc_t_q.delete();
        test_reset();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL stale_output: out_valid=%b busy=%b after reset, required 0/0",
                         bus.out_valid, bus.busy);
            end
        end
        run_one(64'h00000000_000000F0, 1'b1, 6'd4, 0);
    endtask

    task automatic test_random;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [5:0] s;
                    case ($urandom_range(0, 9))
                        0:       s = 6'd0;
                        1:       s = 6'd63;
                        default: s = 6'($urandom_range(0, 63));
                    endcase
                    send_req({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), s);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    collect_resp($urandom_range(0, 2));
                end
            end
        join
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data      = '0;
        bus.dir       = 1'b0;
        bus.shamt     = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_right_undo();
        test_left_undo();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();

        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/funnel_unshift.md
# funnel_unshift

Multi-cycle inverse of the ALU's combinational 64-bit funnel shifter. It accepts a packed 64-bit funnel word, a shift amount and the direction of the original shift. It then applies the opposite logical shift iteratively, STEP bits per cycle, and returns the result split into 32-bit high and low halves. It sits behind the shift unit on a valid/ready interface. It is used for the multi-cycle unpack/undo path, where area matters more than latency.

## Interface
- STEP, default 4: maximum bits shifted per cycle; legal values 1, 2, 4, 8.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- data  input  64  packed funnel word {hi, lo}.
- dir  input  1  direction of the original shift: 1 = original was left, so this block shifts right; 0 = original was right, so this block shifts left.
- shamt  input  6  shift amount, 0..63.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- hi  output  32  result bits [63:32].
- lo  output  32  result bits [31:0].
- busy  output  1  high in SHIFT or DONE.

## Operation
- Registered state: state, acc[63:0], rem[5:0], dir_q.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: acc<=data, rem<=shamt, dir_q<=dir.
  - Next state is DONE if shamt==0, else SHIFT.
  - Inputs are sampled only at acceptance; changes to inputs afterwards have no effect.
- SHIFT, each cycle:
  - k = min(STEP, rem).
  - acc <= dir_q ? acc >> k : acc << k, logical with zero fill.
  - rem <= rem - k.
  - When rem - k == 0, next state is DONE.
- DONE:
  - out_valid=1; hi=acc[63:32], lo=acc[31:0], both held stable.
  - On out_valid & out_ready: go to IDLE.
- in_ready is 0 in SHIFT and DONE. Requests presented then are neither accepted nor lost; the producer holds them.
- Arithmetic:
  - The result equals a single-step logical shift by shamt, exactly.
  - Bits shifted out are discarded; no rotate, no sign fill.
  - rem never underflows.
- hi/lo outside DONE: they show acc and carry no meaning; the consumer uses them only with out_valid.
- Reset (async, any state, including mid-SHIFT or mid-DONE):
  - state=IDLE, acc=0, rem=0, dir_q=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, hi=0, lo=0.
  - Any in-flight request is dropped.
  - Deassertion is not synchronised by this block; the top level supplies a synchronised release.

## Timing
- Acceptance edge E0, meaning in_valid & in_ready are sampled high.
- Number of SHIFT cycles N = ceil(shamt / STEP); N = 0 for shamt = 0.
- out_valid rises in the cycle after edge E0+N:
  - Latency is 1 + N cycles from acceptance to first out_valid.
  - With STEP=4: shamt=0 gives 1 cycle; shamt=31 gives 9; shamt=63 gives 17.
- Backpressure: DONE holds with out_valid=1 and stable hi/lo for as long as out_ready=0.
- Completion at edge Ed (out_valid & out_ready): in_ready=1 in the following cycle.
  - No same-cycle turnaround.
  - Minimum initiation interval is N + 2 cycles.
- in_ready and out_valid are never high in the same cycle.
- All outputs are driven directly from registers or decoded from state; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: rst pulsed mid-run -> in_ready=1, out_valid=0, busy=0, hi=lo=0 immediately (asynchronous), and held while rst stays high.
- Right undo, STEP=4: data=0x00000001_80000000, dir=1, shamt=31 -> out_valid 9 cycles after acceptance, hi=0x00000000, lo=0x00000003.
- Left undo: data=0x00000000_FFFFFFFF, dir=0, shamt=32 -> latency 9, hi=0xFFFFFFFF, lo=0x00000000.
- Boundaries:
  - shamt=0, data=0x12345678_9ABCDEF0 -> latency 1, output equals input.
  - dir=1, shamt=63, data=0x80000000_00000000 -> latency 17, hi=0, lo=0x00000001.
- Backpressure and ordering:
  - Hold out_ready=0 for 5 cycles in DONE -> hi/lo stable, in_ready=0 throughout.
  - Second request held on in_valid during SHIFT/DONE -> accepted only the cycle after completion, with correct result.
- Reset mid-SHIFT: assert rst 3 cycles into a shamt=40 request, then issue a new request shamt=4, data=0xF0, dir=1 -> no stale output; result lo=0x0F after 2 cycles.
- Random self-check (1000 requests, random STEP build): compare against a single-step reference shift; latency must equal 1+ceil(shamt/STEP).
